fixed_latency_divider: RTL and testbench
========================================

Name: fixed_latency_divider

Overview:
- Signed 64-by-32 divider; the inverse companion of the fixed-latency multiplier `multi`.
- Takes a 2*WIDTH-bit dividend (typically a `multi` product) and a WIDTH-bit divisor.
- Returns quotient and remainder a fixed WIDTH+1 clocks after a start edge, using a restoring shift/subtract on magnitudes.
- Uses the same start/valid handshake style as `multi`, so benches and datapaths can chain multiply -> divide.

Parameters:
- WIDTH, 32, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Asserted when 0; acts immediately, independent of clock.
- start  input  1  operation request; only its rising edge (0->1 between samples) is acted on.
- dvd  input  2*WIDTH  signed dividend; sampled on the start edge.
- dvs  input  WIDTH  signed divisor; sampled on the start edge.
- quot  output  WIDTH  signed quotient, truncated toward zero.
- rem  output  WIDTH  signed remainder; sign follows the dividend.
- valid  output  1  result valid; held until the next accepted start or reset.
- busy  output  1  high while computing.
- dbz  output  1  divide-by-zero flag; qualified by valid.
- ovf  output  1  quotient-overflow flag; qualified by valid.

Behaviour:
- Reset (reset=0): state IDLE; quot, rem, valid, busy, dbz, ovf and all internal regs = 0. Applies mid-operation too; the operation is aborted with no result.
- Start edge detect: register start_q; accept = start & ~start_q. A start held high across many cycles launches exactly one operation.
- States:
  - IDLE: on accept, go to CALC.
  - CALC: runs WIDTH iterations, then goes to DONE.
  - DONE: on accept, go to CALC.
- Accept and CALC entry (posedge k):
  - Latch |dvd|, |dvs|, sign_q = dvd[msb]^dvs[msb], sign_r = dvd[msb].
  - busy=1; valid drops to 0.
  - Precompute dbz = (dvs==0).
  - Precompute pre_ovf = (|dvd|[2W-1:W] >= |dvs|), i.e. magnitude quotient >= 2^W.
- Accept while in CALC: ignored.
- Iterations (posedges k+1 .. k+WIDTH): one restoring step per cycle on the magnitudes: shift partial remainder left, trial subtract, set quotient bit. Iteration counter counts 0..WIDTH-1, then wraps to 0.
- Result (posedge k+WIDTH+1), state DONE, busy=0, valid=1. Fixed latency WIDTH+1 (33 at default) for every operand, including dbz and ovf cases. Output selection, first match wins:
  - dbz: quot = all ones, rem = dvd[W-1:0], ovf = 0.
  - overflow = pre_ovf, or mag_q > 2^(W-1)-1 with sign_q=0, or mag_q > 2^(W-1) with sign_q=1. Then ovf=1, rem=0, quot = 0x7FFF_FFFF (sign_q=0) or 0x8000_FFFF... correction: 0x8000_0000 (sign_q=1).
  - otherwise: quot = sign_q ? -mag_q : mag_q; rem = sign_r ? -mag_r : mag_r.
- Exact -2^(W-1) quotient is legal: ovf=0, quot=0x8000_0000.
- Operand inputs may change after the start edge without affecting the in-flight result.
- Outputs are fully registered; no combinational input-to-output path.

Decomposition:
- Package div_pkg holds:
  - WIDTH default.
  - LATENCY = WIDTH+1.
  - state enum {IDLE, CALC, DONE}.
  - Saturation constants QMAX and QMIN.
- One sub-module, div_step: combinational single restoring stage.
  - Inputs: partial remainder, next dividend bit, |dvs|.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once; the top holds the sequential FSM, counter and fixup.

Test Plan:
- dvd=100, dvs=7, start edge -> valid exactly 33 clocks later; quot=14, rem=2, dbz=0, ovf=0.
- dvd=-100, dvs=7 -> quot=0xFFFFFFF2 (-14), rem=0xFFFFFFFE (-2). Then dvd=100, dvs=-7 -> quot=-14, rem=+2.
- Round-trip with `multi`: 10 random pairs; dvd=mlier*mcand, dvs=mcand (nonzero) -> quot=mlier, rem=0, each in 33 clocks.
- dvd=1234, dvs=0 -> dbz=1, quot=0xFFFFFFFF, rem=0x000004D2, valid after 33 clocks.
- Overflow cases:
  - dvd=64'h0000_0001_0000_0000, dvs=1 -> ovf=1, quot=0x7FFFFFFF, rem=0.
  - dvd=64'hFFFF_FFFF_8000_0000, dvs=1 -> ovf=0, quot=0x80000000.
- Control cases:
  - reset=0 at clock 10 of CALC -> all outputs 0 immediately, IDLE.
  - start held high through valid -> no second op.
  - second start edge in CALC -> ignored; original result unchanged.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and types for the fixed-latency restoring divider.
// QMAX/QMIN are the saturated quotients reported on overflow at the default width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int LATENCY       = DEFAULT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } divState_t;

  localparam logic [DEFAULT_WIDTH-1:0] QMAX = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};
  localparam logic [DEFAULT_WIDTH-1:0] QMIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring division stage on magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             bitIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH:0] shifted;

  assign shifted = {remIn, bitIn};
  assign qBit    = (shifted >= {1'b0, divisor});

  // When the subtraction succeeds the true difference fits in WIDTH bits,
  // so the low bits of a WIDTH-bit subtract are exact.
  assign remOut  = qBit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/fixed_latency_divider.sv
// Signed 2W-by-W divider with a fixed W+1 clock latency from the start edge.
// Iterates on magnitudes, then applies sign, divide-by-zero and saturation fixup.
module fixed_latency_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0]   dvs,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               valid,
  output logic               busy,
  output logic               dbz,
  output logic               ovf
);

  localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  divState_t state;
  divState_t stateNext;

  logic             startQ;
  logic             accept;
  logic             loadOp;
  logic             doStep;
  logic             finish;

  logic [CW-1:0]    iterCnt;
  logic             stepsDone;
  logic [WIDTH-1:0] partRem;
  logic [WIDTH-1:0] dvdShift;
  logic [WIDTH-1:0] magQ;
  logic [WIDTH-1:0] magDvs;
  logic [WIDTH-1:0] dvdLow;
  logic             signQ;
  logic             signR;
  logic             dbzPre;
  logic             preOvf;

  logic [2*WIDTH-1:0] dvdMag;
  logic [WIDTH-1:0]   dvsMag;
  logic [WIDTH-1:0]   stepRem;
  logic               stepBit;
  logic               overflow;
  logic [WIDTH-1:0]   quotSigned;
  logic [WIDTH-1:0]   remSigned;

  assign accept = start & ~startQ;
  assign dvdMag = dvd[2*WIDTH-1] ? -dvd : dvd;
  assign dvsMag = dvs[WIDTH-1] ? -dvs : dvs;

  div_step #(
    .WIDTH(WIDTH)
  ) stepUnit (
    .remIn  (partRem),
    .bitIn  (dvdShift[WIDTH-1]),
    .divisor(magDvs),
    .remOut (stepRem),
    .qBit   (stepBit)
  );

  // A quotient of exactly 2^(W-1) is only representable when it is negative.
  assign overflow   = preOvf | (~signQ & magQ[WIDTH-1]) | (signQ & (magQ > SAT_MIN));
  assign quotSigned = signQ ? -magQ : magQ;
  assign remSigned  = signR ? -partRem : partRem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // CALC holds for WIDTH step cycles plus one fixup cycle, so the result lands on a fixed edge.
  always_comb begin
    stateNext = state;
    loadOp    = 1'b0;
    doStep    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = CALC;
          loadOp    = 1'b1;
        end
      end
      CALC: begin
        if (stepsDone) begin
          stateNext = DONE;
          finish    = 1'b1;
        end else begin
          doStep = 1'b1;
        end
      end
      DONE: begin
        if (accept) begin
          stateNext = CALC;
          loadOp    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Seeding the partial remainder with the dividend's upper half needs only W steps;
  // any case where that half is not below the divisor is flagged as overflow up front.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      startQ    <= 1'b0;
      iterCnt   <= '0;
      stepsDone <= 1'b0;
      partRem   <= '0;
      dvdShift  <= '0;
      magQ      <= '0;
      magDvs    <= '0;
      dvdLow    <= '0;
      signQ     <= 1'b0;
      signR     <= 1'b0;
      dbzPre    <= 1'b0;
      preOvf    <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      startQ <= start;
      if (loadOp) begin
        partRem   <= dvdMag[2*WIDTH-1:WIDTH];
        dvdShift  <= dvdMag[WIDTH-1:0];
        magQ      <= '0;
        magDvs    <= dvsMag;
        dvdLow    <= dvd[WIDTH-1:0];
        signQ     <= dvd[2*WIDTH-1] ^ dvs[WIDTH-1];
        signR     <= dvd[2*WIDTH-1];
        dbzPre    <= (dvs == '0);
        preOvf    <= (dvdMag[2*WIDTH-1:WIDTH] >= dvsMag);
        iterCnt   <= '0;
        stepsDone <= 1'b0;
        busy      <= 1'b1;
        valid     <= 1'b0;
      end
      if (doStep) begin
        partRem  <= stepRem;
        dvdShift <= {dvdShift[WIDTH-2:0], 1'b0};
        magQ     <= {magQ[WIDTH-2:0], stepBit};
        if (iterCnt == LAST_ITER) begin
          iterCnt   <= '0;
          stepsDone <= 1'b1;
        end else begin
          iterCnt <= iterCnt + 1'b1;
        end
      end
      if (finish) begin
        stepsDone <= 1'b0;
        busy      <= 1'b0;
        valid     <= 1'b1;
        dbz       <= dbzPre;
        if (dbzPre) begin
          quot <= '1;
          rem  <= dvdLow;
          ovf  <= 1'b0;
        end else if (overflow) begin
          quot <= signQ ? SAT_MIN : SAT_MAX;
          rem  <= '0;
          ovf  <= 1'b1;
        end else begin
          quot <= quotSigned;
          rem  <= remSigned;
          ovf  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_latency_divider.sv
// Scoreboard bench for fixed_latency_divider: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid rises.
module tb_fixed_latency_divider;
  import div_pkg::*;

  typedef struct packed {
    logic [31:0] quot;
    logic [31:0] rem;
    logic        dbz;
    logic        ovf;
    int          cycle;
    int          id;
  } expect_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        valid;
  logic        busy;
  logic        dbz;
  logic        ovf;

  int      checks = 0;
  int      failures = 0;
  int      cycle = 0;
  int      launchCycle = 0;
  int      opId = 0;
  logic    prevValid = 1'b0;
  expect_t sb[$];
  expect_t got;

  fixed_latency_divider #(
    .WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dvd  (dvd),
    .dvs  (dvs),
    .quot (quot),
    .rem  (rem),
    .valid(valid),
    .busy (busy),
    .dbz  (dbz),
    .ovf  (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic void checkOutput(input string name, input logic [63:0] actual,
                                      input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endfunction

  // Monitor: every rising valid must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (valid && !prevValid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 64'(sb.size()), 64'd1);
      end else begin
        got = sb.pop_front();
        checkOutput($sformatf("op%0d quot", got.id), 64'(quot), 64'(got.quot));
        checkOutput($sformatf("op%0d rem", got.id), 64'(rem), 64'(got.rem));
        checkOutput($sformatf("op%0d dbz", got.id), 64'(dbz), 64'(got.dbz));
        checkOutput($sformatf("op%0d ovf", got.id), 64'(ovf), 64'(got.ovf));
        checkOutput($sformatf("op%0d busy", got.id), 64'(busy), 64'd0);
        checkOutput($sformatf("op%0d latency", got.id), 64'(cycle), 64'(got.cycle));
      end
    end
    prevValid <= valid;
  end

  task automatic launch(input logic [63:0] a, input logic [31:0] b, input bit hold);
    @(negedge clock);
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    launchCycle = cycle;
    @(negedge clock);
    dvd = ~a;
    dvs = ~b;
    if (!hold) start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [31:0] b,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input logic expDbz, input logic expOvf, input bit hold);
    expect_t e;
    launch(a, b, hold);
    e.quot  = expQ;
    e.rem   = expR;
    e.dbz   = expDbz;
    e.ovf   = expOvf;
    e.cycle = launchCycle + LATENCY;
    e.id    = opId;
    opId++;
    sb.push_back(e);
  endtask

  task automatic waitResults();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      checkOutput("result_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " quot"}, 64'(quot), 64'd0);
    checkOutput({tag, " rem"}, 64'(rem), 64'd0);
    checkOutput({tag, " valid"}, 64'(valid), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " dbz"}, 64'(dbz), 64'd0);
    checkOutput({tag, " ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  int      mliers[10];
  int      mcands[10];
  longint  prod;

  initial begin
    mliers = '{3, -12345, 2147483647, -7, 65536, 1, int'(32'h80000000), 123456789, 0, -1000000};
    mcands = '{5, 678, 2, -9, 65536, -1, 1, -987, 42, -1000000};

    reset = 1'b0;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] basic signed division");
    applyStimulus(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
    waitResults();
    applyStimulus(-64'd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    waitResults();
    applyStimulus(64'd100, -32'd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 1'b0);
    waitResults();
    applyStimulus(-64'd100, -32'd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    waitResults();

    $display("[TB] multiply round trip");
    for (int i = 0; i < 10; i++) begin
      prod = longint'(mliers[i]) * longint'(mcands[i]);
      applyStimulus(64'(prod), 32'(mcands[i]), 32'(mliers[i]), 32'd0, 1'b0, 1'b0, 1'b0);
      waitResults();
    end

    $display("[TB] divide by zero");
    applyStimulus(64'd1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_04D2, 1'b1, 1'b0, 1'b0);
    waitResults();
    applyStimulus(-64'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0);
    waitResults();

    $display("[TB] overflow boundaries");
    applyStimulus(64'h0000_0001_0000_0000, 32'd1, QMAX, 32'd0, 1'b0, 1'b1, 1'b0);
    waitResults();
    applyStimulus(64'hFFFF_FFFF_8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0);
    waitResults();
    applyStimulus(64'h0000_0000_8000_0000, 32'd1, QMAX, 32'd0, 1'b0, 1'b1, 1'b0);
    waitResults();
    applyStimulus(64'h0000_0000_8000_0000, 32'hFFFF_FFFF, QMIN, 32'd0, 1'b0, 1'b0, 1'b0);
    waitResults();
    applyStimulus(64'hFFFF_FFFF_0000_0000, 32'd1, QMIN, 32'd0, 1'b0, 1'b1, 1'b0);
    waitResults();

    $display("[TB] second start edge during CALC is ignored");
    applyStimulus(64'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    dvd   = 64'd50;
    dvs   = 32'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitResults();
    repeat (40) @(negedge clock);
    checkOutput("ignored_start busy", 64'(busy), 64'd0);
    checkOutput("ignored_start quot", 64'(quot), 64'd142);

    $display("[TB] start held high launches one operation");
    applyStimulus(64'd999, 32'd10, 32'd99, 32'd9, 1'b0, 1'b0, 1'b1);
    waitResults();
    repeat (40) @(negedge clock);
    checkOutput("held_start valid", 64'(valid), 64'd1);
    checkOutput("held_start busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clock);

    $display("[TB] reset aborts an operation in flight");
    launch(64'd5000, 32'd3, 1'b0);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("abort");
    @(negedge clock);
    reset = 1'b1;
    repeat (50) @(negedge clock);
    checkOutput("post_abort valid", 64'(valid), 64'd0);
    checkOutput("post_abort busy", 64'(busy), 64'd0);

    applyStimulus(64'd77, -32'd5, 32'hFFFF_FFF1, 32'd2, 1'b0, 1'b0, 1'b0);
    waitResults();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
